// File: rtl/wb_commit_arbiter_pkg.sv
// Shared constants for the writeback commit arbiter: source indices,
// warp/register index widths and the commit-count width derivation.
package wb_commit_arbiter_pkg;

    // Commit source indices
    localparam int SRC_ALU = 0;
    localparam int SRC_LD  = 1;
    localparam int SRC_CSR = 2;
    localparam int SRC_FPU = 3;

    // Index widths
    localparam int NW_BITS = 2;
    localparam int NR_BITS = 5;

    // Width that can hold every lane of every source firing at once
    function automatic int cmt_width(input int num_reqs, input int num_threads);
        return $clog2(num_reqs * num_threads + 1);
    endfunction

endpackage

// File: rtl/wb_commit_arbiter_if.sv
// Commit-side request bundle plus writeback and commit-count outputs.
// slave is the arbiter's view, master is the view of whoever drives commits.
interface wb_commit_arbiter_if
    import wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int CMTW        = cmt_width(NUM_REQS, NUM_THREADS)
) ();

    logic [NUM_REQS-1:0]               req_valid;
    logic [NUM_REQS-1:0]               req_ready;
    logic [NUM_REQS-1:0]               req_wb;
    logic [NUM_REQS*NW_BITS-1:0]       req_wid;
    logic [NUM_REQS*NUM_THREADS-1:0]   req_tmask;
    logic [NUM_REQS*NR_BITS-1:0]       req_rd;
    logic [NUM_REQS*NUM_THREADS*XLEN-1:0] req_data;

    logic                              wb_valid;
    logic [NW_BITS-1:0]                wb_wid;
    logic [NUM_THREADS-1:0]            wb_tmask;
    logic [NR_BITS-1:0]                wb_rd;
    logic [NUM_THREADS*XLEN-1:0]       wb_data;

    logic                              cmt_valid;
    logic [CMTW-1:0]                   cmt_size;

    modport slave (
        input  req_valid, req_wb, req_wid, req_tmask, req_rd, req_data,
        output req_ready,
        output wb_valid, wb_wid, wb_tmask, wb_rd, wb_data,
        output cmt_valid, cmt_size
    );

    modport master (
        output req_valid, req_wb, req_wid, req_tmask, req_rd, req_data,
        input  req_ready,
        input  wb_valid, wb_wid, wb_tmask, wb_rd, wb_data,
        input  cmt_valid, cmt_size
    );

endinterface

// File: rtl/wb_commit_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter. The pointer marks the highest-priority
// index; after a grant it moves to one past the winner so every requester
// is served within N-1 cycles of its competitors.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          hi_any;
    logic          lo_any;

    // Lowest requester at or above the pointer wins; otherwise wrap to the
    // lowest requester overall. Scanning downward leaves the lowest match.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_i[j] && (IW'(j) >= ptr_q)) begin
                hi_idx = IW'(j);
                hi_any = 1'b1;
            end
            if (req_i[j]) begin
                lo_idx = IW'(j);
                lo_any = 1'b1;
            end
        end
        grant_any_o = lo_any;
        grant_idx_o = hi_any ? hi_idx : lo_idx;
        grant_oh_o  = lo_any ? ({{(N-1){1'b0}}, 1'b1} << grant_idx_o) : '0;
    end

    // Next pointer: one past the winner, wrapping at N-1; hold when idle
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any_o) begin
            ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_commit_arbiter.sv
// Shares the register-file writeback port between the commit sources.
// Non-writing commits are drained immediately; one writing commit per cycle
// is granted round-robin and registered onto the writeback bus, and the
// number of lanes committed is reported one cycle later.
module wb_commit_arbiter
    import wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int CMTW        = cmt_width(NUM_REQS, NUM_THREADS)
) (
    input  logic               clk,
    input  logic               reset,
    wb_commit_arbiter_if.slave bus
);

    localparam int IW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int DW = NUM_THREADS * XLEN;

    logic [NUM_REQS-1:0]             wr_req;
    logic [NUM_REQS-1:0]             grant_oh;
    logic [IW-1:0]                   grant_idx;
    logic                            grant_any;
    logic [NUM_REQS-1:0]             fire;
    logic [NUM_REQS*NUM_THREADS-1:0] fired_tmask;

    logic                   wb_valid_q;
    logic [NW_BITS-1:0]     wb_wid_q,   wb_wid_d;
    logic [NUM_THREADS-1:0] wb_tmask_q, wb_tmask_d;
    logic [NR_BITS-1:0]     wb_rd_q,    wb_rd_d;
    logic [DW-1:0]          wb_data_q,  wb_data_d;
    logic                   cmt_valid_q;
    logic [CMTW-1:0]        cmt_size_q, cmt_size_d;

    assign wr_req = bus.req_valid & bus.req_wb;

    rr_arbiter #(
        .N (NUM_REQS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (wr_req),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    // Non-writers never touch the port, so they are accepted unconditionally
    assign bus.req_ready = (bus.req_valid & ~bus.req_wb) | grant_oh;
    assign fire          = bus.req_valid & bus.req_ready;

    // Lane masks of sources that actually fired this cycle
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_fired_mask
        assign fired_tmask[gi*NUM_THREADS +: NUM_THREADS] =
            fire[gi] ? bus.req_tmask[gi*NUM_THREADS +: NUM_THREADS] : '0;
    end

    // Count every fired lane across all sources
    always_comb begin
        cmt_size_d = '0;
        for (int i = 0; i < NUM_REQS * NUM_THREADS; i++) begin
            cmt_size_d = cmt_size_d + CMTW'(fired_tmask[i]);
        end
    end

    // Payload mux: take the grantee's fields, hold the old ones otherwise
    always_comb begin
        wb_wid_d   = wb_wid_q;
        wb_tmask_d = wb_tmask_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_any && (grant_idx == IW'(i))) begin
                wb_wid_d   = bus.req_wid[i*NW_BITS +: NW_BITS];
                wb_tmask_d = bus.req_tmask[i*NUM_THREADS +: NUM_THREADS];
                wb_rd_d    = bus.req_rd[i*NR_BITS +: NR_BITS];
                wb_data_d  = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Writeback and commit-count output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q  <= 1'b0;
            wb_wid_q    <= '0;
            wb_tmask_q  <= '0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            cmt_valid_q <= 1'b0;
            cmt_size_q  <= '0;
        end else begin
            wb_valid_q  <= grant_any;
            wb_wid_q    <= wb_wid_d;
            wb_tmask_q  <= wb_tmask_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            cmt_valid_q <= |fire;
            cmt_size_q  <= cmt_size_d;
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_wid    = wb_wid_q;
    assign bus.wb_tmask  = wb_tmask_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.cmt_valid = cmt_valid_q;
    assign bus.cmt_size  = cmt_size_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Scoreboard bench for wb_commit_arbiter: the driver applies commits on the
// falling edge, checks req_ready against a reference model and queues the
// expected registered outputs; a monitor compares them after each rising edge.
module tb_wb_commit_arbiter;
    import wb_commit_arbiter_pkg::*;

    localparam int NR   = 4;
    localparam int NT   = 4;
    localparam int XL   = 32;
    localparam int DW   = NT * XL;
    localparam int CMTW = cmt_width(NR, NT);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    wb_commit_arbiter_if #(.NUM_REQS(NR), .NUM_THREADS(NT), .XLEN(XL), .CMTW(CMTW)) bus ();

    wb_commit_arbiter #(
        .NUM_REQS    (NR),
        .NUM_THREADS (NT),
        .XLEN        (XL),
        .CMTW        (CMTW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               wb_valid;
        logic [NW_BITS-1:0] wid;
        logic [NT-1:0]      tmask;
        logic [NR_BITS-1:0] rd;
        logic [DW-1:0]      data;
        logic               cmt_valid;
        logic [CMTW-1:0]    cmt_size;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Pending requests per source (held until accepted)
    logic               p_valid [NR];
    logic               p_wb    [NR];
    logic [NW_BITS-1:0] p_wid   [NR];
    logic [NT-1:0]      p_tmask [NR];
    logic [NR_BITS-1:0] p_rd    [NR];
    logic [DW-1:0]      p_data  [NR];

    // Reference model state
    int                 m_ptr;
    logic [NW_BITS-1:0] m_wid;
    logic [NT-1:0]      m_tmask;
    logic [NR_BITS-1:0] m_rd;
    logic [DW-1:0]      m_data;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic set_req(int s, bit wb, logic [NW_BITS-1:0] wid, logic [NT-1:0] tm,
                           logic [NR_BITS-1:0] rd, logic [31:0] base, bit rnd);
        p_valid[s] = 1'b1;
        p_wb[s]    = wb;
        p_wid[s]   = wid;
        p_tmask[s] = tm;
        p_rd[s]    = rd;
        for (int l = 0; l < NT; l++) begin
            p_data[s][l*XL +: XL] = rnd ? $urandom : base + 32'(l);
        end
    endtask

    // Drive pending requests, check ready, queue expected next-cycle outputs
    task automatic apply();
        logic [NR-1:0]         v, w;
        logic [NR*NW_BITS-1:0] wid_v;
        logic [NR*NT-1:0]      tm_v;
        logic [NR*NR_BITS-1:0] rd_v;
        logic [NR*DW-1:0]      dat_v;
        int                    win;
        int                    size;
        bit                    any_fire;
        bit                    rdy [NR];
        exp_t                  e;
        for (int i = 0; i < NR; i++) begin
            v[i] = p_valid[i];
            w[i] = p_wb[i];
            wid_v[i*NW_BITS +: NW_BITS] = p_wid[i];
            tm_v[i*NT +: NT]            = p_tmask[i];
            rd_v[i*NR_BITS +: NR_BITS]  = p_rd[i];
            dat_v[i*DW +: DW]           = p_data[i];
        end
        bus.req_valid = v;
        bus.req_wb    = w;
        bus.req_wid   = wid_v;
        bus.req_tmask = tm_v;
        bus.req_rd    = rd_v;
        bus.req_data  = dat_v;
        #1;
        // Winner: first writer visited when walking the sources from ptr
        win = -1;
        for (int k = 0; k < NR; k++) begin
            int s;
            s = (m_ptr + k) % NR;
            if (win < 0 && p_valid[s] && p_wb[s]) win = s;
        end
        size = 0;
        any_fire = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rdy[i] = p_valid[i] && (!p_wb[i] || i == win);
            check($sformatf("ready[%0d]", i), DW'(bus.req_ready[i]), DW'(rdy[i]));
            if (rdy[i]) begin
                size += $countones(p_tmask[i]);
                any_fire = 1'b1;
            end
        end
        if (win >= 0) begin
            m_wid   = p_wid[win];
            m_tmask = p_tmask[win];
            m_rd    = p_rd[win];
            m_data  = p_data[win];
            m_ptr   = (win + 1) % NR;
        end
        e.wb_valid  = (win >= 0);
        e.wid       = m_wid;
        e.tmask     = m_tmask;
        e.rd        = m_rd;
        e.data      = m_data;
        e.cmt_valid = any_fire;
        e.cmt_size  = CMTW'(size);
        exp_q.push_back(e);
        for (int i = 0; i < NR; i++) begin
            if (rdy[i]) p_valid[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        apply();
    endtask

    // Assert reset asynchronously, check the cleared outputs, release on a falling edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_wb_valid",  DW'(bus.wb_valid),  '0);
        check("rst_cmt_valid", DW'(bus.cmt_valid), '0);
        check("rst_cmt_size",  DW'(bus.cmt_size),  '0);
        check("rst_wb_rd",     DW'(bus.wb_rd),     '0);
        check("rst_wb_tmask",  DW'(bus.wb_tmask),  '0);
        check("rst_wb_wid",    DW'(bus.wb_wid),    '0);
        check("rst_wb_data",   bus.wb_data,        '0);
        for (int i = 0; i < NR; i++) p_valid[i] = 1'b0;
        bus.req_valid = '0;
        m_ptr   = 0;
        m_wid   = '0;
        m_tmask = '0;
        m_rd    = '0;
        m_data  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare registered outputs against the scoreboard head
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wb_valid",  DW'(bus.wb_valid),  DW'(e.wb_valid));
            check("cmt_valid", DW'(bus.cmt_valid), DW'(e.cmt_valid));
            check("cmt_size",  DW'(bus.cmt_size),  DW'(e.cmt_size));
            check("wb_wid",    DW'(bus.wb_wid),    DW'(e.wid));
            check("wb_tmask",  DW'(bus.wb_tmask),  DW'(e.tmask));
            check("wb_rd",     DW'(bus.wb_rd),     DW'(e.rd));
            check("wb_data",   bus.wb_data,        e.data);
            $display("txn t=%0t wb_valid=%0d wid=%0d rd=%0d tmask=%b cmt_valid=%0d cmt_size=%0d",
                     $time, bus.wb_valid, bus.wb_wid, bus.wb_rd, bus.wb_tmask,
                     bus.cmt_valid, bus.cmt_size);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            p_valid[i] = 1'b0;
            p_wb[i]    = 1'b0;
            p_wid[i]   = '0;
            p_tmask[i] = '0;
            p_rd[i]    = '0;
            p_data[i]  = '0;
        end
        bus.req_valid = '0;
        bus.req_wb    = '0;
        bus.req_wid   = '0;
        bus.req_tmask = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        do_reset();

        // All four writers from reset: grants 0,1,2,3 in order
        for (int s = 0; s < NR; s++) begin
            set_req(s, 1'b1, NW_BITS'(s), NT'(s + 1), NR_BITS'(s + 8), 32'h100 * s, 1'b0);
        end
        repeat (4) step();

        // Single ALU write with ptr back at 0
        set_req(SRC_ALU, 1'b1, 2'd1, 4'b1011, 5'd5, 32'hA, 1'b0);
        step();

        // CSR write moves ptr to 3
        set_req(SRC_CSR, 1'b1, 2'd2, 4'b0110, 5'd7, 32'h20, 1'b0);
        step();

        // Wrap: ptr=3 with ALU and FPU writing -> FPU then ALU
        set_req(SRC_ALU, 1'b1, 2'd0, 4'b0001, 5'd1,  32'h30, 1'b0);
        set_req(SRC_FPU, 1'b1, 2'd3, 4'b1000, 5'd31, 32'h40, 1'b0);
        step();
        step();

        // Mixed: LD non-writer plus FPU writer, counted together
        set_req(SRC_LD,  1'b0, 2'd1, 4'b1111, 5'd0, 32'h50, 1'b0);
        set_req(SRC_FPU, 1'b1, 2'd2, 4'b0011, 5'd9, 32'h60, 1'b0);
        step();

        // Idle: outputs drop, payload holds
        step();
        step();

        // Empty lane mask is still a valid write
        set_req(SRC_CSR, 1'b1, 2'd0, 4'b0000, 5'd3, 32'h70, 1'b0);
        step();

        // Reset mid-burst while a write is on the bus
        for (int s = 0; s < NR; s++) begin
            set_req(s, 1'b1, NW_BITS'(s), 4'b1111, NR_BITS'(s + 16), 32'h200 * s, 1'b0);
        end
        step();
        @(posedge clk);
        #3;
        check("pre_reset_wb_valid", DW'(bus.wb_valid), DW'(1));
        do_reset();
        set_req(SRC_LD,  1'b1, 2'd1, 4'b0101, 5'd11, 32'h80, 1'b0);
        set_req(SRC_FPU, 1'b1, 2'd3, 4'b1010, 5'd12, 32'h90, 1'b0);
        step();
        step();

        // Randomized traffic with held requests
        for (int n = 0; n < 400; n++) begin
            for (int s = 0; s < NR; s++) begin
                if (!p_valid[s] && $urandom_range(0, 99) < 60) begin
                    set_req(s, 1'($urandom_range(0, 99) < 70), NW_BITS'($urandom),
                            NT'($urandom), NR_BITS'($urandom), 32'h0, 1'b1);
                end
            end
            step();
            if (n == 200) begin
                @(posedge clk);
                #3;
                do_reset();
            end
        end

        for (int i = 0; i < NR; i++) p_valid[i] = 1'b0;
        step();
        repeat (3) @(negedge clk);
        check("queue_drain", DW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_commit_arbiter.md
# wb_commit_arbiter

Shares the single register-file writeback port between the ALU, load, CSR and FPU commit streams. Each cycle it grants one writing commit by round-robin and drains all non-writing commits (wb=0) at once. It registers the winner onto the writeback bus and reports the per-cycle committed-thread count to the CSR unit. It sits between the execute-stage commit interfaces and the issue-stage register file.

## Interface
- NUM_REQS, 4, number of commit sources; index 0=ALU, 1=LD, 2=CSR, 3=FPU.
- NUM_THREADS, 4, lanes per warp.
- NW_BITS, 2, warp-id width.
- NR_BITS, 5, register-index width.
- XLEN, 32, lane data width.
- CMTW, $clog2(NUM_REQS*NUM_THREADS+1), commit-count width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQS  commit valid per source.
- req_ready  out  NUM_REQS  commit accepted this cycle (combinational).
- req_wb  in  NUM_REQS  source writes a register.
- req_wid  in  NUM_REQS*NW_BITS  warp id.
- req_tmask  in  NUM_REQS*NUM_THREADS  thread mask.
- req_rd  in  NUM_REQS*NR_BITS  destination register.
- req_data  in  NUM_REQS*NUM_THREADS*XLEN  lane results.
- wb_valid  out  1  register-file write strobe.
- wb_wid  out  NW_BITS  warp id.
- wb_tmask  out  NUM_THREADS  lane write enables.
- wb_rd  out  NR_BITS  destination register.
- wb_data  out  NUM_THREADS*XLEN  write data.
- cmt_valid  out  1  at least one commit fired in the previous cycle.
- cmt_size  out  CMTW  popcount of the tmasks fired in the previous cycle.

## Operation
- Writing request i: req_valid[i] && req_wb[i]. Non-writing request: req_valid[i] && !req_wb[i].
- Every non-writing request gets req_ready=1 in the same cycle, unconditionally. It never uses the port.
- Among writing requests, exactly one is granted: the first set bit scanning from the priority pointer ptr upward, modulo NUM_REQS. The grantee gets req_ready=1; all other writing requests get req_ready=0.
- A source with valid=0 gets req_ready=0.
- Pointer update on a grant to index g: ptr <= (g+1) mod NUM_REQS. With no grant, ptr holds.
- Output register loads on every clock:
  - wb_valid <= grant_any.
  - On a grant, wb_wid/wb_tmask/wb_rd/wb_data are loaded from the grantee.
  - With no grant, the wb_* data fields hold their old values.
- Commit counter:
  - cmt_size <= popcount of the concatenated tmasks of every source with valid && ready. This covers the granted writer plus all non-writers.
  - cmt_valid <= (any fire).
- Requesters must hold valid and payload stable until ready. The block relies on this and does not check it.
- No back-pressure from the register file; the port accepts one write per cycle.

## Timing
- req_ready is combinational from req_valid, req_wb and ptr. It must not depend on any other request input.
- Latency from fire to wb_valid/cmt_valid is exactly 1 cycle. Throughput is one writeback per cycle.
- Reset (asynchronous assert, synchronous-safe deassert) sets:
  - ptr=0, wb_valid=0, wb_wid=0, wb_tmask=0, wb_rd=0, wb_data=0, cmt_valid=0, cmt_size=0.
- Reset asserted mid-stream: an in-flight registered write is lost, and wb_valid drops in the same cycle (asynchronous). Sources re-present their requests after reset.
- Simultaneous requests:
  - All writing sources valid with ptr=k: grant k. Others wait, and each is guaranteed a grant within NUM_REQS-1 further cycles.
  - A writer and non-writers firing in the same cycle are all counted in the same cmt_size.
- Wrap-around: grant to NUM_REQS-1 sets ptr=0.
- Maximum cmt_size is NUM_REQS*NUM_THREADS (16 at the defaults), which CMTW must hold.
- A tmask of 0 with valid=1 is legal. It is granted normally and contributes 0 to cmt_size; wb_valid is still 1.

## Structure
- Shared package entries: the source-index constants (SRC_ALU=0, SRC_LD=1, SRC_CSR=2, SRC_FPU=3), NW_BITS and NR_BITS, and the CMTW derivation.
- One sub-module: rr_arbiter (NUM_REQS-wide, with its own pointer register, grant one-hot and grant index). It is reused by other shared-port blocks.
- The top level contains the non-writer bypass, the payload mux, the output register and the popcount register.

## Test plan
- Single ALU write: ALU valid, wb=1, wid=1, rd=5, tmask=4'b1011, data lanes 0xA..0xD. Required: ready=1 the same cycle; next cycle wb_valid=1, wb_rd=5, wb_tmask=1011, cmt_size=3; ptr=1.
- All four writers valid for 4 cycles from reset. Required: grants 0,1,2,3 in order; wb_valid=1 for 4 consecutive cycles; each source sees ready exactly once.
- Wrap: ptr=3 with sources 0 and 3 writing. Required: grant 3, then grant 0 the next cycle; ptr ends at 1.
- Mixed: LD wb=0 tmask=1111 and FPU wb=1 tmask=0011 in the same cycle. Required: both ready=1; next cycle wb_valid=1 with FPU payload and cmt_size=6.
- Idle: no requests. Required: wb_valid=0 and cmt_valid=0 the next cycle; the wb_* data fields and ptr are unchanged.
- Reset mid-burst: assert reset while wb_valid=1. Required: wb_valid=0, cmt_size=0 and ptr=0 immediately; after deassert, the first grant goes to the lowest valid writer.
